// File: rtl/flags_pkg.sv
// Shared constants and types for the 8088 FLAGS register.
// Bit positions, command codes and fixed/writable masks.
package flags_pkg;

  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int AF_BIT = 4;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int TF_BIT = 8;
  localparam int IF_BIT = 9;
  localparam int DF_BIT = 10;
  localparam int OF_BIT = 11;

  localparam int M_CF = 0;
  localparam int M_PF = 1;
  localparam int M_AF = 2;
  localparam int M_ZF = 3;
  localparam int M_SF = 4;
  localparam int M_OF = 5;

  localparam logic [15:0] FLAGS_RESET = 16'hF002;
  localparam logic [15:0] FIXED_ONES  = 16'hF002;
  localparam logic [15:0] WR_MASK     = 16'h0FD5;
  localparam logic [15:0] SAHF_MASK   = 16'h00D5;

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_CLC  = 4'd1,
    CMD_STC  = 4'd2,
    CMD_CMC  = 4'd3,
    CMD_CLI  = 4'd4,
    CMD_STI  = 4'd5,
    CMD_CLD  = 4'd6,
    CMD_STD  = 4'd7,
    CMD_LOAD = 4'd8,
    CMD_SAHF = 4'd9
  } flag_cmd_e;

  typedef struct packed {
    logic       valid;
    logic [5:0] mask;
  } cap_stage_t;

  function automatic logic [15:0] spread6(
    input logic [5:0] v
  );
    logic [15:0] r;
    r         = '0;
    r[CF_BIT] = v[M_CF];
    r[PF_BIT] = v[M_PF];
    r[AF_BIT] = v[M_AF];
    r[ZF_BIT] = v[M_ZF];
    r[SF_BIT] = v[M_SF];
    r[OF_BIT] = v[M_OF];
    return r;
  endfunction

  function automatic logic [15:0] fix_flags(
    input logic [15:0] f
  );
    return (f & WR_MASK) | FIXED_ONES;
  endfunction

endpackage

// File: rtl/flags_if.sv
// ALU/sequencer side signals of the FLAGS unit.
// master drives ALU results and commands; slave is the unit.
interface flags_if;
  logic        aluIssue;
  logic [5:0]  aluMask;
  logic        F_Overflow;
  logic        F_Neg;
  logic        F_Zero;
  logic        F_Aux;
  logic        F_Parity;
  logic        F_Carry;
  logic [3:0]  flagCmd;
  logic [15:0] flagData;
  logic [15:0] FLAGS;
  logic        carryOut;
  logic        carryHazard;
  logic        flagsPending;

  modport master (
    output aluIssue, aluMask,
    output F_Overflow, F_Neg, F_Zero,
    output F_Aux, F_Parity, F_Carry,
    output flagCmd, flagData,
    input  FLAGS, carryOut,
    input  carryHazard, flagsPending
  );

  modport slave (
    input  aluIssue, aluMask,
    input  F_Overflow, F_Neg, F_Zero,
    input  F_Aux, F_Parity, F_Carry,
    input  flagCmd, flagData,
    output FLAGS, carryOut,
    output carryHazard, flagsPending
  );
endinterface

// File: rtl/flags_capture_pipe.sv
// Two-stage valid+mask shift register that tracks ALU flag latency.
// Stage 2 valid marks the edge where ALU flags are captured.
module flags_capture_pipe
  import flags_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_i,
  input  logic [5:0] mask_i,
  output logic       cap_o,
  output logic [5:0] cap_mask_o,
  output logic       hazard_o,
  output logic       pending_o
);

  cap_stage_t s1_q, s1_d;
  cap_stage_t s2_q, s2_d;

  always_comb begin
    s1_d.valid = issue_i & (|mask_i);
    s1_d.mask  = mask_i;
    s2_d       = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign cap_o      = s2_q.valid;
  assign cap_mask_o = s2_q.mask;
  assign hazard_o   = (s1_q.valid & s1_q.mask[M_CF])
                    | (s2_q.valid & s2_q.mask[M_CF]);
  assign pending_o  = s1_q.valid | s2_q.valid;

endmodule

// File: rtl/flags_unit.sv
// Architectural FLAGS register: ALU capture, flag commands,
// and CF feedback with an in-flight carry hazard.
module flags_unit
  import flags_pkg::*;
(
  input  logic  CLKx4,
  input  logic  RESETn,
  flags_if.slave bus
);

  logic [15:0] flags_q, flags_d;
  logic        cap;
  logic [5:0]  cap_mask;
  logic [15:0] cap_bits;
  logic [15:0] cap_vals;
  logic [15:0] merged;
  logic [15:0] cmd_bits;
  logic [15:0] cmd_vals;
  logic [5:0]  alu_f;
  flag_cmd_e   cmd;

  flags_capture_pipe u_pipe (
    .clk        (CLKx4),
    .rst_n      (RESETn),
    .issue_i    (bus.aluIssue),
    .mask_i     (bus.aluMask),
    .cap_o      (cap),
    .cap_mask_o (cap_mask),
    .hazard_o   (bus.carryHazard),
    .pending_o  (bus.flagsPending)
  );

  assign alu_f = {bus.F_Overflow, bus.F_Neg,
                  bus.F_Zero, bus.F_Aux,
                  bus.F_Parity, bus.F_Carry};

  assign cap_bits = cap ? spread6(cap_mask) : '0;
  assign cap_vals = spread6(alu_f);
  assign merged   = (flags_q & ~cap_bits)
                  | (cap_vals & cap_bits);

  assign cmd = flag_cmd_e'(bus.flagCmd);

  always_comb begin
    cmd_bits = '0;
    cmd_vals = '0;
    unique case (1'b1)
      (cmd == CMD_CLC): begin
        cmd_bits[CF_BIT] = 1'b1;
      end
      (cmd == CMD_STC): begin
        cmd_bits[CF_BIT] = 1'b1;
        cmd_vals[CF_BIT] = 1'b1;
      end
      (cmd == CMD_CMC): begin
        cmd_bits[CF_BIT] = 1'b1;
        cmd_vals[CF_BIT] = ~flags_q[CF_BIT];
      end
      (cmd == CMD_CLI): begin
        cmd_bits[IF_BIT] = 1'b1;
      end
      (cmd == CMD_STI): begin
        cmd_bits[IF_BIT] = 1'b1;
        cmd_vals[IF_BIT] = 1'b1;
      end
      (cmd == CMD_CLD): begin
        cmd_bits[DF_BIT] = 1'b1;
      end
      (cmd == CMD_STD): begin
        cmd_bits[DF_BIT] = 1'b1;
        cmd_vals[DF_BIT] = 1'b1;
      end
      (cmd == CMD_LOAD): begin
        cmd_bits = WR_MASK;
        cmd_vals = bus.flagData;
      end
      (cmd == CMD_SAHF): begin
        cmd_bits = SAHF_MASK;
        cmd_vals = bus.flagData;
      end
      default: begin
        cmd_bits = '0;
      end
    endcase
  end

  // Command bits override the capture; fixed bits forced last
  assign flags_d = fix_flags((merged & ~cmd_bits)
                           | (cmd_vals & cmd_bits));

  always_ff @(posedge CLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      flags_q <= FLAGS_RESET;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.FLAGS    = flags_q;
  assign bus.carryOut = flags_q[CF_BIT];

endmodule

// File: tb/tb_flags_unit.sv
// Directed bench for flags_unit with an event-scheduled
// reference model of the architectural FLAGS register.
module tb_flags_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  int   checks = 0;
  int   fails = 0;

  flags_if bus ();

  flags_unit dut (
    .CLKx4  (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ALU result vector {OF,SF,ZF,AF,PF,CF} of the op issued
  // this cycle, delayed two edges as the ALU would.
  logic [5:0] cur_f = '0;
  logic [5:0] alu1 = '0;
  logic [5:0] alu2 = '0;

  always @(posedge clk) begin
    alu1 <= cur_f;
    alu2 <= alu1;
  end

  assign bus.F_Overflow = alu2[5];
  assign bus.F_Neg      = alu2[4];
  assign bus.F_Zero     = alu2[3];
  assign bus.F_Aux      = alu2[2];
  assign bus.F_Parity   = alu2[1];
  assign bus.F_Carry    = alu2[0];

  typedef struct {
    int         due;
    logic [5:0] m;
    logic [5:0] f;
  } pend_t;

  pend_t       pq[$];
  logic [15:0] mflags = 16'hF002;
  int          ecount = 0;

  function automatic logic [15:0] place(
    input logic [15:0] f,
    input logic [5:0]  m,
    input logic [5:0]  v
  );
    int pos[6] = '{0, 2, 4, 6, 7, 11};
    logic [15:0] r;
    r = f;
    for (int k = 0; k < 6; k++)
      if (m[k]) r[pos[k]] = v[k];
    return r;
  endfunction

  function automatic logic [15:0] apply_cmd(
    input logic [15:0] f,
    input logic [3:0]  c,
    input logic [15:0] d
  );
    logic [15:0] r;
    r = f;
    case (c)
      4'd1: r[0] = 1'b0;
      4'd2: r[0] = 1'b1;
      4'd3: r[0] = ~f[0];
      4'd4: r[9] = 1'b0;
      4'd5: r[9] = 1'b1;
      4'd6: r[10] = 1'b0;
      4'd7: r[10] = 1'b1;
      4'd8: r = d;
      4'd9: begin
        r[7] = d[7];
        r[6] = d[6];
        r[4] = d[4];
        r[2] = d[2];
        r[0] = d[0];
      end
      default: r = f;
    endcase
    return {4'hF, r[11:6], 1'b0, r[4], 1'b0, r[2], 1'b1, r[0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete();
      mflags = 16'hF002;
      ecount = 0;
    end else begin
      ecount++;
      for (int i = pq.size() - 1; i >= 0; i--) begin
        if (pq[i].due == ecount) begin
          mflags = place(mflags, pq[i].m, pq[i].f);
          pq.delete(i);
        end
      end
      mflags = apply_cmd(mflags, bus.flagCmd, bus.flagData);
      if (bus.aluIssue && bus.aluMask != 6'd0)
        pq.push_back('{ecount + 2, bus.aluMask, cur_f});
    end
  end

  task automatic chk(
    input string       nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic model_hazard();
    logic h;
    h = 1'b0;
    foreach (pq[i]) if (pq[i].m[0]) h = 1'b1;
    return h;
  endfunction

  always @(posedge clk) begin
    #1;
    if (run) begin
      chk("model_flags", bus.FLAGS, mflags);
      chk("model_cout", {15'd0, bus.carryOut},
          {15'd0, mflags[0]});
      chk("model_hazard", {15'd0, bus.carryHazard},
          {15'd0, model_hazard()});
      chk("model_pending", {15'd0, bus.flagsPending},
          {15'd0, pq.size() != 0});
    end
  end

  task automatic step(
    input logic        iss,
    input logic [5:0]  m,
    input logic [5:0]  f,
    input logic [3:0]  c,
    input logic [15:0] d
  );
    bus.aluIssue = iss;
    bus.aluMask  = m;
    cur_f        = f;
    bus.flagCmd  = c;
    bus.flagData = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 6'd0, 4'd0, 16'h0000);
  endtask

  initial begin
    bus.aluIssue = 1'b0;
    bus.aluMask  = '0;
    bus.flagCmd  = '0;
    bus.flagData = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    chk("reset_flags", bus.FLAGS, 16'hF002);
    chk("reset_pend", {15'd0, bus.flagsPending}, 16'd0);

    // 7FFF+0001: OF SF AF PF set, ZF CF clear
    step(1'b1, 6'h3F, 6'b110110, 4'd0, 16'h0);
    chk("add_haz_e0", {15'd0, bus.carryHazard}, 16'd1);
    chk("add_flags_e0", bus.FLAGS, 16'hF002);
    idle();
    chk("add_haz_e1", {15'd0, bus.carryHazard}, 16'd1);
    chk("add_flags_e1", bus.FLAGS, 16'hF002);
    idle();
    chk("add_flags_e2", bus.FLAGS, 16'hF896);
    chk("add_haz_e2", {15'd0, bus.carryHazard}, 16'd0);

    // STC then INC leaves CF alone
    step(1'b0, 6'd0, 6'd0, 4'd2, 16'h0);
    chk("stc", bus.FLAGS, 16'hF897);
    step(1'b1, 6'h3E, 6'b010100, 4'd0, 16'h0);
    chk("inc_no_haz", {15'd0, bus.carryHazard}, 16'd0);
    idle();
    idle();
    chk("inc_flags", bus.FLAGS, 16'hF093);

    // back-to-back issues
    step(1'b1, 6'h3F, 6'b000001, 4'd0, 16'h0);
    step(1'b1, 6'h3F, 6'b001000, 4'd0, 16'h0);
    step(1'b1, 6'h3F, 6'b100010, 4'd0, 16'h0);
    chk("b2b_a", bus.FLAGS, 16'hF003);
    idle();
    chk("b2b_b", bus.FLAGS, 16'hF042);
    idle();
    chk("b2b_c", bus.FLAGS, 16'hF806);

    // capture CF/ZF with CLC on the capture edge
    step(1'b1, 6'b001001, 6'b001001, 4'd0, 16'h0);
    idle();
    step(1'b0, 6'd0, 6'd0, 4'd1, 16'h0);
    chk("cap_clc", bus.FLAGS, 16'hF846);

    step(1'b0, 6'd0, 6'd0, 4'd8, 16'h0000);
    chk("load0", bus.FLAGS, 16'hF002);
    step(1'b0, 6'd0, 6'd0, 4'd8, 16'hFFFF);
    chk("loadF", bus.FLAGS, 16'hFFD7);
    step(1'b0, 6'd0, 6'd0, 4'd9, 16'hFF00);
    chk("sahf", bus.FLAGS, 16'hFF02);
    step(1'b0, 6'd0, 6'd0, 4'd3, 16'h0);
    chk("cmc", bus.FLAGS, 16'hFF03);
    step(1'b0, 6'd0, 6'd0, 4'd4, 16'h0);
    chk("cli", bus.FLAGS, 16'hFD03);
    step(1'b0, 6'd0, 6'd0, 4'd6, 16'h0);
    chk("cld", bus.FLAGS, 16'hF903);
    step(1'b0, 6'd0, 6'd0, 4'd12, 16'hFFFF);
    chk("reserved", bus.FLAGS, 16'hF903);
    step(1'b0, 6'd0, 6'd0, 4'd5, 16'h0);
    step(1'b0, 6'd0, 6'd0, 4'd7, 16'h0);
    chk("sti_std", bus.FLAGS, 16'hFF03);

    // reset between E0 and E1 discards the capture
    step(1'b1, 6'h3F, 6'b111111, 4'd0, 16'h0);
    chk("rst_pre_pend", {15'd0, bus.flagsPending}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_flags", bus.FLAGS, 16'hF002);
    chk("rst_pend", {15'd0, bus.flagsPending}, 16'd0);
    bus.aluIssue = 1'b0;
    bus.aluMask  = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_after", bus.FLAGS, 16'hF002);
      chk("rst_after_pend", {15'd0, bus.flagsPending}, 16'd0);
    end

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
